// File: rtl/dispatch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_buffer_pkg
// Shared core constants used by the decode/dispatch path.
//   CORE_BUF_DEPTH  : dispatch buffer entries (power of two, >= 4)
//   CORE_INST_WIDTH : instruction word width
//   DISPATCH_WIDTH  : instructions moved per cycle in and out of the buffer
//   IQ_DEPTH        : issue-queue depth downstream of the buffer
// -----------------------------------------------------------------------------
package dispatch_buffer_pkg;

  localparam int CORE_BUF_DEPTH  = 8;
  localparam int CORE_INST_WIDTH = 32;
  localparam int DISPATCH_WIDTH  = 4;
  localparam int IQ_DEPTH        = 7;

endpackage : dispatch_buffer_pkg

// File: rtl/dispatch_buffer.sv
// -----------------------------------------------------------------------------
// dispatch_buffer
// Circular FIFO between decode and the issue queue. Accepts a group of up to
// four instructions per cycle and presents up to four of the oldest entries
// per cycle; the group is popped only when the issue queue reports success.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid, in_num      : decode group valid and size (legal 1..4)
//   in_inst0..in_inst3    : group slots, slot 0 oldest
//   in_ready              : free space >= in_num (registered count only)
//   flush                 : discard all buffered entries at the next edge
//   din0..din3            : entries offered to the issue queue, din0 oldest
//   write_num, write_en   : number offered (0..4) and write request
//   write_success         : issue queue accepted all write_num entries
//   occupancy             : current entry count
// -----------------------------------------------------------------------------
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int DEPTH = CORE_BUF_DEPTH,
  parameter int WIDTH = CORE_INST_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_num,
  input  logic [WIDTH-1:0] in_inst0,
  input  logic [WIDTH-1:0] in_inst1,
  input  logic [WIDTH-1:0] in_inst2,
  input  logic [WIDTH-1:0] in_inst3,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] din0,
  output logic [WIDTH-1:0] din1,
  output logic [WIDTH-1:0] din2,
  output logic [WIDTH-1:0] din3,
  output logic [2:0]       write_num,
  output logic             write_en,
  input  logic             write_success,
  output logic [3:0]       occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] in_arr  [DISPATCH_WIDTH];
  logic [WIDTH-1:0] din_arr [DISPATCH_WIDTH];
  logic [CW-1:0]    free_cnt;
  logic             num_legal;
  logic             push;
  logic             pop;

  assign in_arr[0] = in_inst0;
  assign in_arr[1] = in_inst1;
  assign in_arr[2] = in_inst2;
  assign in_arr[3] = in_inst3;

  assign din0 = din_arr[0];
  assign din1 = din_arr[1];
  assign din2 = din_arr[2];
  assign din3 = din_arr[3];

  assign occupancy = 4'(count_q);

  // Handshake and read-side presentation, all from registered state so a
  // same-cycle pop never frees space for a same-cycle push.
  always_comb begin
    free_cnt  = CW'(DEPTH) - count_q;
    in_ready  = free_cnt >= CW'(in_num);
    num_legal = (in_num != 3'd0) && (in_num <= 3'd4);
    push      = in_valid & in_ready & num_legal & ~flush;
    write_num = (count_q >= CW'(4)) ? 3'd4 : 3'(count_q);
    write_en  = (count_q != '0) & ~flush;
    pop       = write_en & write_success;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      din_arr[k] = '0;
      if (3'(k) < write_num) begin
        din_arr[k] = mem_q[rd_ptr_q + PW'(k)];
      end
    end
  end

  // Next-state: storage writes for the pushed slots, pointer/count updates.
  // Flush wins over any same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (3'(k) < in_num) begin
          mem_d[wr_ptr_q + PW'(k)] = in_arr[k];
        end
      end
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(in_num);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(write_num);
      end
      count_d = count_q + (push ? CW'(in_num) : '0) - (pop ? CW'(write_num) : '0);
    end
  end

  // Control state; reset overrides flush, push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale words are masked by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : dispatch_buffer

// File: tb/tb_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// tb_dispatch_buffer
// Directed, table-driven bench for dispatch_buffer. Each record holds the
// inputs for one cycle and the outputs expected in that same cycle (before the
// clock edge that consumes the inputs).
// -----------------------------------------------------------------------------
module tb_dispatch_buffer;

  typedef logic [3:0][31:0] grp_t;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [2:0] num;
    grp_t       inst;
    logic       flush;
    logic       ws;
    logic       chk_ready;
    logic       exp_ready;
    logic       exp_we;
    logic [2:0] exp_wn;
    grp_t       exp_din;
    logic [3:0] exp_occ;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_num;
  logic [31:0] in_inst0, in_inst1, in_inst2, in_inst3;
  logic        in_ready;
  logic        flush;
  logic [31:0] din0, din1, din2, din3;
  logic [2:0]  write_num;
  logic        write_en;
  logic        write_success;
  logic [3:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  localparam grp_t Z = '0;

  dispatch_buffer #(.DEPTH(8), .WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_num        (in_num),
    .in_inst0      (in_inst0),
    .in_inst1      (in_inst1),
    .in_inst2      (in_inst2),
    .in_inst3      (in_inst3),
    .in_ready      (in_ready),
    .flush         (flush),
    .din0          (din0),
    .din1          (din1),
    .din2          (din2),
    .din3          (din3),
    .write_num     (write_num),
    .write_en      (write_en),
    .write_success (write_success),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Four consecutive words starting at base, slot 0 = base.
  function automatic grp_t grp(input logic [31:0] base);
    grp_t g;
    for (int k = 0; k < 4; k++) g[k] = base + 32'(k);
    return g;
  endfunction

  function automatic vec_t mk(input logic rst, input logic valid, input logic [2:0] num,
                              input grp_t inst, input logic fl, input logic ws,
                              input logic chk_r, input logic r, input logic we,
                              input logic [2:0] wn, input grp_t d, input logic [3:0] occ);
    vec_t v;
    v.rst = rst; v.valid = valid; v.num = num; v.inst = inst; v.flush = fl; v.ws = ws;
    v.chk_ready = chk_r; v.exp_ready = r; v.exp_we = we; v.exp_wn = wn;
    v.exp_din = d; v.exp_occ = occ;
    return v;
  endfunction

  // Drive one cycle of inputs with blocking assignments.
  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    in_valid      = v.valid;
    in_num        = v.num;
    in_inst0      = v.inst[0];
    in_inst1      = v.inst[1];
    in_inst2      = v.inst[2];
    in_inst3      = v.inst[3];
    flush         = v.flush;
    write_success = v.ws;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the combinational outputs for the current cycle.
  task automatic checkOutput(input string tag, input vec_t v);
    grp_t d;
    d = {din3, din2, din1, din0};
    if (v.chk_ready) cmp({tag, ".in_ready"}, 32'(in_ready), 32'(v.exp_ready));
    cmp({tag, ".write_en"},  32'(write_en),  32'(v.exp_we));
    cmp({tag, ".write_num"}, 32'(write_num), 32'(v.exp_wn));
    cmp({tag, ".occupancy"}, 32'(occupancy), 32'(v.exp_occ));
    for (int k = 0; k < 4; k++) cmp($sformatf("%s.din%0d", tag, k), d[k], v.exp_din[k]);
  endtask

  // Inputs change just after the falling edge, outputs sampled 1ns later,
  // the rising edge then consumes the inputs.
  task automatic runCycle(input string tag, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(tag, v);
    @(posedge clk);
  endtask

  task automatic idleReset();
    @(negedge clk);
    applyStimulus(mk(1, 0, 3'd1, Z, 0, 0, 0, 0, 0, 3'd0, Z, 4'd0));
    @(posedge clk);
    @(posedge clk);
  endtask

  localparam logic [31:0] A = 32'hA000_0000;
  localparam logic [31:0] D = 32'hD000_0000;
  localparam logic [31:0] E = 32'hE000_0000;
  localparam logic [31:0] F = 32'hF000_0000;
  localparam logic [31:0] G = 32'h6000_0000;
  localparam logic [31:0] H = 32'h7000_0000;
  localparam logic [31:0] J = 32'h8000_0000;
  localparam logic [31:0] K = 32'h9000_0000;

  vec_t tbl [19];
  vec_t v;
  grp_t ga, gh, gj;

  initial begin
    reset = 1'b1; in_valid = 0; in_num = 3'd1; flush = 0; write_success = 0;
    in_inst0 = '0; in_inst1 = '0; in_inst2 = '0; in_inst3 = '0;

    ga = grp(A);
    gh = grp(H);
    gj = grp(J);
    // slot 3 of the 3-instruction group carries junk that must never appear
    ga[3] = 32'hBAD0_BAD0;

    //            rst valid num  inst          fl ws chk rdy we wn    din                          occ
    tbl[0]  = mk(0, 0, 3'd1, Z,              0, 0, 1, 1, 0, 3'd0, Z,                           4'd0);
    tbl[1]  = mk(0, 1, 3'd3, ga,             0, 1, 1, 1, 0, 3'd0, Z,                           4'd0);
    tbl[2]  = mk(0, 0, 3'd1, Z,              0, 1, 1, 1, 1, 3'd3, {32'h0, A+2, A+1, A},        4'd3);
    tbl[3]  = mk(0, 0, 3'd1, Z,              0, 0, 1, 1, 0, 3'd0, Z,                           4'd0);
    tbl[4]  = mk(0, 1, 3'd4, grp(D),         0, 0, 1, 1, 0, 3'd0, Z,                           4'd0);
    tbl[5]  = mk(0, 1, 3'd2, grp(D+4),       0, 0, 1, 1, 1, 3'd4, grp(D),                      4'd4);
    tbl[6]  = mk(0, 1, 3'd3, grp(E),         0, 0, 1, 0, 1, 3'd4, grp(D),                      4'd6);
    tbl[7]  = mk(0, 1, 3'd2, grp(F),         0, 0, 1, 1, 1, 3'd4, grp(D),                      4'd6);
    tbl[8]  = mk(0, 1, 3'd1, grp(E),         0, 0, 1, 0, 1, 3'd4, grp(D),                      4'd8);
    tbl[9]  = mk(0, 0, 3'd1, Z,              0, 1, 1, 0, 1, 3'd4, grp(D),                      4'd8);
    tbl[10] = mk(0, 1, 3'd1, grp(G),         0, 1, 1, 1, 1, 3'd4, {F+1, F, D+5, D+4},          4'd4);
    tbl[11] = mk(0, 1, 3'd4, gh,             0, 0, 1, 1, 1, 3'd1, {32'h0, 32'h0, 32'h0, G},    4'd1);
    tbl[12] = mk(0, 1, 3'd2, gj,             0, 1, 1, 1, 1, 3'd4, {H+2, H+1, H, G},            4'd5);
    tbl[13] = mk(0, 0, 3'd1, Z,              0, 0, 1, 1, 1, 3'd3, {32'h0, J+1, J, H+3},        4'd3);
    tbl[14] = mk(0, 1, 3'd2, grp(K),         1, 1, 1, 1, 0, 3'd3, {32'h0, J+1, J, H+3},        4'd3);
    tbl[15] = mk(0, 0, 3'd1, Z,              0, 0, 1, 1, 0, 3'd0, Z,                           4'd0);
    tbl[16] = mk(0, 1, 3'd0, grp(K),         0, 0, 0, 0, 0, 3'd0, Z,                           4'd0);
    tbl[17] = mk(0, 1, 3'd5, grp(K),         0, 0, 0, 0, 0, 3'd0, Z,                           4'd0);
    tbl[18] = mk(0, 0, 3'd1, Z,              0, 0, 1, 1, 0, 3'd0, Z,                           4'd0);

    idleReset();
    for (int i = 0; i < 19; i++) runCycle($sformatf("tbl%0d", i), tbl[i]);

    // Wrap: move both pointers to 6, then stream 4-in/4-out across 7->0.
    idleReset();
    runCycle("wrap_set0", mk(0, 1, 3'd4, grp(32'h1000_0000), 0, 0, 1, 1, 0, 3'd0, Z, 4'd0));
    runCycle("wrap_set1", mk(0, 0, 3'd1, Z, 0, 1, 1, 1, 1, 3'd4, grp(32'h1000_0000), 4'd4));
    runCycle("wrap_set2", mk(0, 1, 3'd2, grp(32'h2000_0000), 0, 0, 1, 1, 0, 3'd0, Z, 4'd0));
    runCycle("wrap_set3", mk(0, 0, 3'd1, Z, 0, 1, 1, 1, 1, 3'd2,
                             {32'h0, 32'h0, 32'h2000_0001, 32'h2000_0000}, 4'd2));
    for (int i = 0; i < 4; i++) begin
      if (i == 0)
        v = mk(0, 1, 3'd4, grp(32'hC000_0000), 0, 1, 1, 1, 0, 3'd0, Z, 4'd0);
      else
        v = mk(0, 1, 3'd4, grp(32'hC000_0000 + 32'(i * 16)), 0, 1, 1, 1, 1, 3'd4,
               grp(32'hC000_0000 + 32'((i - 1) * 16)), 4'd4);
      runCycle($sformatf("wrap%0d", i), v);
    end
    runCycle("wrap_last", mk(0, 0, 3'd1, Z, 0, 1, 1, 1, 1, 3'd4, grp(32'hC000_0030), 4'd4));
    runCycle("wrap_empty", mk(0, 0, 3'd1, Z, 0, 0, 1, 1, 0, 3'd0, Z, 4'd0));

    // Retry: the same four entries are held while the issue queue refuses.
    runCycle("retry_push", mk(0, 1, 3'd4, grp(32'h5000_0000), 0, 0, 1, 1, 0, 3'd0, Z, 4'd0));
    for (int i = 0; i < 3; i++)
      runCycle($sformatf("retry%0d", i),
               mk(0, 0, 3'd1, Z, 0, 0, 1, 1, 1, 3'd4, grp(32'h5000_0000), 4'd4));
    runCycle("retry_ok", mk(0, 0, 3'd1, Z, 0, 1, 1, 1, 1, 3'd4, grp(32'h5000_0000), 4'd4));
    runCycle("retry_done", mk(0, 0, 3'd1, Z, 0, 0, 1, 1, 0, 3'd0, Z, 4'd0));

    // Reset while a group is being retried drops it.
    runCycle("rst_push", mk(0, 1, 3'd2, grp(32'h3000_0000), 0, 0, 1, 1, 0, 3'd0, Z, 4'd0));
    runCycle("rst_hold", mk(0, 0, 3'd1, Z, 0, 0, 1, 1, 1, 3'd2,
                            {32'h0, 32'h0, 32'h3000_0001, 32'h3000_0000}, 4'd2));
    runCycle("rst_apply", mk(1, 1, 3'd1, grp(32'h4000_0000), 0, 1, 1, 1, 1, 3'd2,
                             {32'h0, 32'h0, 32'h3000_0001, 32'h3000_0000}, 4'd2));
    runCycle("rst_after", mk(0, 0, 3'd1, Z, 0, 0, 1, 1, 0, 3'd0, Z, 4'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dispatch_buffer
